// File: rtl/i2c_target_regs_if.sv
// I2C pad-side bus bundle for i2c_target_regs.
//   scl_i  : SCL pad input (asynchronous)
//   sda_i  : SDA pad input (asynchronous)
//   sda_oe : 1 = pull SDA low, 0 = release SDA
// The slave modport is the target view; the master modport is the host/pad view.
interface i2c_target_regs_if;
  logic scl_i;
  logic sda_i;
  logic sda_oe;

  modport slave (
    input  scl_i,
    input  sda_i,
    output sda_oe
  );

  modport master (
    output scl_i,
    output sda_i,
    input  sda_oe
  );
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target exposing an ID byte, a status byte and the 80-bit BCD measurement
// results as read-only registers, plus one control register.
// Ports:
//   clock        system clock, at least 20x the SCL rate
//   reset        synchronous active-low reset
//   i2c          SCL/SDA pad inputs and SDA open-drain enable (slave modport)
//   bcdcount     {avg,max,min,cur} BCD results, 20 bits each
//   status       status bits
//   ctrl         control register [6:0]
//   clear_stats  one-cycle pulse when a write to 0x0C has data bit 7 set
//   busy         high from an address match until the next START or STOP
// Optional feature: define I2C_TARGET_WRITE_EN to accept register writes.
// Without it every data byte in a write is NACKed and ctrl/clear_stats stay 0.
module i2c_target_regs #(
  parameter logic [6:0]  TARGET_ADDR = 7'h42,
  parameter logic [7:0]  ID_VALUE    = 8'hA5,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic                clock,
  input  logic                reset,
  i2c_target_regs_if.slave    i2c,
  input  logic [79:0]         bcdcount,
  input  logic [7:0]          status,
  output logic [6:0]          ctrl,
  output logic                clear_stats,
  output logic                busy
);

  localparam int unsigned FLT_W = 4;
  localparam int unsigned BCD_W = 80;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACKCHK, S_IGNORE
  } state_e;

  // Index 0 = SCL, index 1 = SDA
  logic [1:0]            sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]            flt_q, flt_d, prev_q, prev_d;
  logic [1:0][FLT_W-1:0] cnt_q, cnt_d;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         tx_q, tx_d;
  logic [3:0]         ptr_q, ptr_d;
  logic               rw_q, rw_d;
  logic               ack_q, ack_d;
  logic               sda_oe_q, sda_oe_d;
  logic               busy_q, busy_d;
  logic [6:0]         ctrl_q, ctrl_d;
  logic               clear_q, clear_d;
  logic [7:0]         snap_status_q, snap_status_d;
  logic [BCD_W-1:0]   snap_bcd_q, snap_bcd_d;

  logic       scl, sda, scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rd_byte;
  logic [6:0] bidx;

  // Synchronizer plus level filter: a new level needs FILTER_LEN equal samples
  always_comb begin
    sync1_d = {i2c.sda_i, i2c.scl_i};
    sync2_d = sync1_q;
    prev_d  = flt_q;
    flt_d   = flt_q;
    cnt_d   = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != flt_q[i]) begin
        if (cnt_q[i] == FLT_W'(FILTER_LEN - 1)) flt_d[i] = sync2_q[i];
        else                                     cnt_d[i] = cnt_q[i] + FLT_W'(1);
      end
    end
  end

  // Bus events on filtered levels
  always_comb begin
    scl       = flt_q[0];
    sda       = flt_q[1];
    scl_rise  = scl & ~prev_q[0];
    scl_fall  = ~scl & prev_q[0];
    start_det = scl & prev_q[0] & prev_q[1] & ~sda;
    stop_det  = scl & prev_q[0] & ~prev_q[1] & sda;
  end

  // Read register map; bcd bytes are little-endian from 0x02
  always_comb begin
    bidx = {ptr_q - 4'd2, 3'b000};
    case (ptr_q)
      4'h0:                          rd_byte = ID_VALUE;
      4'h1:                          rd_byte = snap_status_q;
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
      4'h7, 4'h8, 4'h9, 4'hA, 4'hB:  rd_byte = snap_bcd_q[bidx +: 8];
      4'hC:                          rd_byte = {1'b0, ctrl_q};
      default:                       rd_byte = 8'h00;
    endcase
  end

  // Protocol FSM next-state and outputs
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    tx_d          = tx_q;
    ptr_d         = ptr_q;
    rw_d          = rw_q;
    ack_d         = ack_q;
    sda_oe_d      = sda_oe_q;
    busy_d        = busy_q;
    ctrl_d        = ctrl_q;
    clear_d       = 1'b0;
    snap_status_d = snap_status_q;
    snap_bcd_d    = snap_bcd_q;

    case (state_q)
      S_ADDR, S_PTR, S_WR_DATA: begin
        if (scl_rise) begin
          shift_d   = {shift_q[6:0], sda};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
        if (scl_fall && bit_cnt_q == CNT_W'(8)) begin
          if (state_q == S_ADDR) begin
            if (shift_q[7:1] == TARGET_ADDR) begin
              state_d  = S_ADDR_ACK;
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              rw_d     = shift_q[0];
              // Snapshot taken with the ACK so a whole read is coherent
              if (shift_q[0]) begin
                snap_status_d = status;
                snap_bcd_d    = bcdcount;
              end
            end else begin
              state_d = S_IGNORE;
            end
          end else if (state_q == S_PTR) begin
            ptr_d    = shift_q[3:0];
            state_d  = S_PTR_ACK;
            sda_oe_d = 1'b1;
          end else begin
`ifdef I2C_TARGET_WRITE_EN
            state_d  = S_WR_ACK;
            sda_oe_d = 1'b1;
            ptr_d    = ptr_q + 4'd1;
            if (ptr_q == 4'hC) begin
              ctrl_d  = shift_q[6:0];
              clear_d = shift_q[7];
            end
`else
            state_d = S_IGNORE;
`endif
          end
        end
      end
      S_ADDR_ACK: begin
        if (scl_fall) begin
          bit_cnt_d = '0;
          if (rw_q) begin
            state_d  = S_RD_DATA;
            tx_d     = rd_byte;
            sda_oe_d = ~rd_byte[7];
          end else begin
            state_d  = S_PTR;
            sda_oe_d = 1'b0;
          end
        end
      end
      S_PTR_ACK, S_WR_ACK: begin
        if (scl_fall) begin
          state_d   = S_WR_DATA;
          bit_cnt_d = '0;
          sda_oe_d  = 1'b0;
        end
      end
      S_RD_DATA: begin
        if (scl_rise) bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (scl_fall) begin
          if (bit_cnt_q == CNT_W'(8)) begin
            state_d  = S_RD_ACKCHK;
            sda_oe_d = 1'b0;
            ptr_d    = ptr_q + 4'd1;
          end else begin
            tx_d     = {tx_q[6:0], 1'b0};
            sda_oe_d = ~tx_q[6];
          end
        end
      end
      S_RD_ACKCHK: begin
        if (scl_rise) ack_d = sda;
        if (scl_fall) begin
          if (!ack_q) begin
            state_d   = S_RD_DATA;
            bit_cnt_d = '0;
            tx_d      = rd_byte;
            sda_oe_d  = ~rd_byte[7];
          end else begin
            state_d = S_IGNORE;
          end
        end
      end
      S_IDLE, S_IGNORE: ;
      default: state_d = S_IDLE;
    endcase

    // START/STOP win in every state and abort any partial byte
    if (start_det) begin
      state_d   = S_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (stop_det) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q       <= 2'b11;
      sync2_q       <= 2'b11;
      flt_q         <= 2'b11;
      prev_q        <= 2'b11;
      cnt_q         <= '0;
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      tx_q          <= '0;
      ptr_q         <= '0;
      rw_q          <= 1'b0;
      ack_q         <= 1'b0;
      sda_oe_q      <= 1'b0;
      busy_q        <= 1'b0;
      ctrl_q        <= '0;
      clear_q       <= 1'b0;
      snap_status_q <= '0;
      snap_bcd_q    <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      flt_q         <= flt_d;
      prev_q        <= prev_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      tx_q          <= tx_d;
      ptr_q         <= ptr_d;
      rw_q          <= rw_d;
      ack_q         <= ack_d;
      sda_oe_q      <= sda_oe_d;
      busy_q        <= busy_d;
      ctrl_q        <= ctrl_d;
      clear_q       <= clear_d;
      snap_status_q <= snap_status_d;
      snap_bcd_q    <= snap_bcd_d;
    end
  end

  assign i2c.sda_oe  = sda_oe_q;
  assign ctrl        = ctrl_q;
  assign clear_stats = clear_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: a host model drives SCL/SDA; expected values are
// queued at stimulus time and a negedge monitor compares them against observations.
module tb_i2c_target_regs;

  localparam int unsigned Q = 20;  // clocks per quarter SCL period

  logic        clk = 1'b0;
  logic        rst_n;
  logic        host_sda;
  logic [79:0] bcdcount;
  logic [7:0]  status;
  logic [6:0]  ctrl;
  logic        clear_stats;
  logic        busy;

  always #5 clk = ~clk;

  i2c_target_regs_if bus();
  assign bus.sda_i = host_sda & ~bus.sda_oe;  // open-drain wired-AND

  i2c_target_regs #(
    .TARGET_ADDR (7'h42),
    .ID_VALUE    (8'hA5),
    .FILTER_LEN  (4)
  ) dut (
    .clock       (clk),
    .reset       (rst_n),
    .i2c         (bus),
    .bcdcount    (bcdcount),
    .status      (status),
    .ctrl        (ctrl),
    .clear_stats (clear_stats),
    .busy        (busy)
  );

  typedef struct {
    string      name;
    logic [7:0] val;
  } obs_t;

  obs_t        exp_q[$];
  obs_t        act_q[$];
  obs_t        mon_a, mon_e;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned clr_cycles = 0;

  // Monitor: pair each observation with the oldest queued expectation
  always @(negedge clk) begin
    if (clear_stats === 1'b1) clr_cycles++;
    while (act_q.size() > 0) begin
      mon_a = act_q.pop_front();
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL %s: got %h, no expected value queued", mon_a.name, mon_a.val);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_a.val !== mon_e.val) begin
          n_err++;
          $display("FAIL %s: got %h, expected %h", mon_a.name, mon_a.val, mon_e.val);
        end
      end
    end
  end

  task automatic push_exp(input string name, input logic [7:0] v);
    obs_t o;
    o.name = name; o.val = v;
    exp_q.push_back(o);
  endtask

  task automatic push_act(input string name, input logic [7:0] v);
    obs_t o;
    o.name = name; o.val = v;
    act_q.push_back(o);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    push_exp(name, exp);
    push_act(name, act);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period; returns the SDA line level sampled while SCL is high
  task automatic bit_tx(input logic b, output logic rx);
    host_sda = b;     wait_clk(Q);
    bus.scl_i = 1'b1; wait_clk(Q);
    rx = bus.sda_i;   wait_clk(Q);
    bus.scl_i = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_start;
    host_sda = 1'b1;  wait_clk(Q);
    bus.scl_i = 1'b1; wait_clk(Q);
    host_sda = 1'b0;  wait_clk(Q);
    bus.scl_i = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop;
    host_sda = 1'b0;  wait_clk(Q);
    bus.scl_i = 1'b1; wait_clk(Q);
    host_sda = 1'b1;  wait_clk(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, input logic exp_ack, input string name);
    logic rx;
    push_exp(name, {7'd0, exp_ack});
    for (int i = 7; i >= 0; i--) bit_tx(d[i], rx);
    bit_tx(1'b1, rx);
    push_act(name, {7'd0, rx});
  endtask

  task automatic rd_byte(input logic [7:0] exp, input logic host_nack, input string name);
    logic [7:0] v;
    logic       rx;
    push_exp(name, exp);
    for (int i = 7; i >= 0; i--) begin
      bit_tx(1'b1, rx);
      v[i] = rx;
    end
    push_act(name, v);
    bit_tx(host_nack, rx);
  endtask

  // 80'h12345_00999_00100_00250 split into bytes, least significant first
  logic [7:0]  t2_exp [10] = '{8'h50, 8'h02, 8'h00, 8'h10, 8'h00,
                               8'h99, 8'h09, 8'h50, 8'h34, 8'h12};
  logic [6:0]  exp_ctrl;
  int unsigned clr_base;
  logic        rx;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    bus.scl_i = 1'b1;
    host_sda  = 1'b1;
    bcdcount  = 80'h12345_00999_00100_00250;
    status    = 8'h03;
    exp_ctrl  = 7'h00;
    wait_clk(3);
    check("rst_sda_oe", {7'd0, bus.sda_oe}, 8'h00);
    check("rst_ctrl", {1'b0, ctrl}, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'h00);
    check("rst_clear", {7'd0, clear_stats}, 8'h00);
    rst_n = 1'b1;
    wait_clk(10);

    // Read ID at the reset pointer
    i2c_start;
    wr_byte(8'h85, 1'b0, "t1_addr_r");
    check("t1_busy", {7'd0, busy}, 8'h01);
    rd_byte(8'hA5, 1'b1, "t1_id");
    i2c_stop;
    check("t1_busy_after_stop", {7'd0, busy}, 8'h00);

    // Pointer write, repeated START, coherent 10-byte read
    i2c_start;
    wr_byte(8'h84, 1'b0, "t2_addr_w");
    wr_byte(8'h02, 1'b0, "t2_ptr");
    i2c_start;
    wr_byte(8'h85, 1'b0, "t2_addr_r");
    for (int i = 0; i < 10; i++) begin
      if (i == 3) bcdcount = ~bcdcount;
      rd_byte(t2_exp[i], (i == 9), $sformatf("t2_byte%0d", i));
    end
    i2c_stop;

    // Foreign address ignored until STOP, then a normal read
    i2c_start;
    wr_byte(8'h86, 1'b1, "t3_addr_nack");
    check("t3_busy", {7'd0, busy}, 8'h00);
    wr_byte(8'h00, 1'b1, "t3_ignored_byte");
    check("t3_busy_ignore", {7'd0, busy}, 8'h00);
    i2c_stop;
    i2c_start;
    wr_byte(8'h84, 1'b0, "t3_addr_w");
    wr_byte(8'h01, 1'b0, "t3_ptr");
    i2c_start;
    wr_byte(8'h85, 1'b0, "t3_addr_r");
    rd_byte(8'h03, 1'b1, "t3_status");
    i2c_stop;

    // Control register write and readback
    clr_base = clr_cycles;
    i2c_start;
    wr_byte(8'h84, 1'b0, "t4_addr_w");
    wr_byte(8'h0C, 1'b0, "t4_ptr");
`ifdef I2C_TARGET_WRITE_EN
    exp_ctrl = 7'h23;
    wr_byte(8'hA3, 1'b0, "t4_data_ack");
    i2c_stop;
    check("t4_ctrl", {1'b0, ctrl}, 8'h23);
    check("t4_clear_cycles", 8'(clr_cycles - clr_base), 8'h01);
`else
    wr_byte(8'hA3, 1'b1, "t4_data_nack");
    i2c_stop;
    check("t4_ctrl", {1'b0, ctrl}, 8'h00);
    check("t4_clear_cycles", 8'(clr_cycles - clr_base), 8'h00);
`endif
    i2c_start;
    wr_byte(8'h84, 1'b0, "t4_addr_w2");
    wr_byte(8'h0C, 1'b0, "t4_ptr2");
    i2c_start;
    wr_byte(8'h85, 1'b0, "t4_addr_r");
    rd_byte({1'b0, exp_ctrl}, 1'b1, "t4_readback");
    i2c_stop;

    // Pointer wrap, host NACK, then target stays off the bus
    i2c_start;
    wr_byte(8'h84, 1'b0, "t5_addr_w");
    wr_byte(8'h0F, 1'b0, "t5_ptr");
    i2c_start;
    wr_byte(8'h85, 1'b0, "t5_addr_r");
    rd_byte(8'h00, 1'b0, "t5_reg0f");
    rd_byte(8'hA5, 1'b1, "t5_wrap_id");
    rd_byte(8'hFF, 1'b1, "t5_ignore_released");
    check("t5_sda_oe", {7'd0, bus.sda_oe}, 8'h00);
    i2c_stop;

    // STOP mid data byte aborts the write
    clr_base = clr_cycles;
    i2c_start;
    wr_byte(8'h84, 1'b0, "t6_addr_w");
    wr_byte(8'h0C, 1'b0, "t6_ptr");
    for (int i = 0; i < 4; i++) bit_tx(1'b1, rx);
    i2c_stop;
    wait_clk(Q);
    check("t6_ctrl", {1'b0, ctrl}, {1'b0, exp_ctrl});
    check("t6_busy", {7'd0, busy}, 8'h00);
    check("t6_clear_cycles", 8'(clr_cycles - clr_base), 8'h00);

    // One-clock SDA glitch with SCL high must not look like START
    host_sda = 1'b0;
    wait_clk(1);
    host_sda = 1'b1;
    wait_clk(Q);
    wr_byte(8'h84, 1'b1, "t6_no_start_after_glitch");
    check("t6_busy_glitch", {7'd0, busy}, 8'h00);
    i2c_stop;

    // Reset while the target is driving ACK releases SDA
    i2c_start;
    push_exp("t7_ack_driven", 8'h01);
    for (int i = 7; i >= 0; i--) bit_tx(((8'h85 >> i) & 8'h01) != 8'h00, rx);
    push_act("t7_ack_driven", {7'd0, bus.sda_oe});
    rst_n = 1'b0;
    wait_clk(1);
    check("t7_sda_oe_reset", {7'd0, bus.sda_oe}, 8'h00);
    check("t7_busy_reset", {7'd0, busy}, 8'h00);
    rst_n = 1'b1;
    wait_clk(Q);
    i2c_stop;

    wait_clk(5);
    if (exp_q.size() != 0) begin
      n_err += exp_q.size();
      $display("FAIL drain: %0d expectations unmatched, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
